// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage sitting directly behind pc_gen.
//
// Issues in-order word requests for the current PC over a valid/ready
// handshake, remembers the PC of every accepted request in an in-flight
// queue, and buffers returned words together with their PCs in a small
// FIFO that feeds decode over a second valid/ready handshake. pc_stall
// holds pc_gen unless a request is accepted or a redirect (flush) occurs.
//
// Parameters:
//   DEPTH               in-flight requests plus buffered entries (2..8)
// Ports:
//   clk_i, rst_ni       clock (rising edge), async active-low reset
//   pc_i / pc_stall_o   current PC from pc_gen / hold request to pc_gen
//   flush_i             redirect; clears the FIFO, marks in-flight as stale
//   imem_req_*          request channel (addr = pc_i)
//   imem_rsp_*          in-order response channel, no backpressure
//   id_*                FIFO head towards decode (instr, pc, fault)
// Build options:
//   IF_MISALIGN_CHECK_EN  when defined, a PC with pc_i[1:0]!=0 is never sent
//                         to memory; once the pipe is empty a single fault
//                         entry (NOP) is queued and fetch stalls until flush.
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    output logic        pc_stall_o,
    input  logic        flush_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        imem_rsp_err_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        id_fault_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [CW-1:0] out_cnt_reg, drop_cnt_reg, fifo_cnt_reg;
    logic [PW-1:0] pq_wr_reg, pq_rd_reg, ff_wr_reg, ff_rd_reg;
    logic [31:0]   pq_pc_reg    [DEPTH];
    logic [31:0]   ff_instr_reg [DEPTH];
    logic [31:0]   ff_pc_reg    [DEPTH];
    logic          ff_fault_reg [DEPTH];

    logic          id_pop, accept, rsp_push, ff_push, credit;
    logic          mis_block, mis_push;
    logic [CW:0]   used;
    logic [31:0]   push_instr, push_pc;
    logic          push_fault;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign id_valid_o = (fifo_cnt_reg != '0);
    assign id_pop     = id_valid_o && id_ready_i;
    assign id_instr_o = ff_instr_reg[ff_rd_reg];
    assign id_pc_o    = ff_pc_reg[ff_rd_reg];
    assign id_fault_o = ff_fault_reg[ff_rd_reg];

    // An entry leaving towards decode this cycle frees its slot immediately,
    // which is what lets DEPTH=2 sustain one fetch per cycle.
    assign used   = {1'b0, out_cnt_reg} + {1'b0, fifo_cnt_reg} - {{CW{1'b0}}, id_pop};
    assign credit = (used < (CW + 1)'(DEPTH));

`ifdef IF_MISALIGN_CHECK_EN
    logic mis_done_reg;

    // mis_done_reg keeps fetch parked after the fault entry until a redirect.
    assign mis_block = (pc_i[1:0] != 2'b00) || mis_done_reg;
    assign mis_push  = rst_ni && !flush_i && (pc_i[1:0] != 2'b00) && !mis_done_reg
                       && (out_cnt_reg == '0) && (fifo_cnt_reg < CW'(DEPTH));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mis_done_reg <= 1'b0;
        end else if (flush_i) begin
            mis_done_reg <= 1'b0;
        end else if (mis_push) begin
            mis_done_reg <= 1'b1;
        end
    end
`else
    assign mis_block = 1'b0;
    assign mis_push  = 1'b0;
`endif

    // Gated by rst_ni so nothing is requested and the PC is held while in reset.
    assign imem_req_valid_o = rst_ni && !flush_i && credit && !mis_block;
    assign imem_req_addr_o  = pc_i;
    assign accept           = imem_req_valid_o && imem_req_ready_i;
    assign pc_stall_o       = !rst_ni || (!accept && !flush_i);

    // A response arriving during a flush belongs to the old path as well.
    assign rsp_push = imem_rsp_valid_i && (drop_cnt_reg == '0) && !flush_i;
    assign ff_push  = rsp_push || mis_push;

    always_comb begin
        push_instr = imem_rsp_err_i ? NOP : imem_rsp_data_i;
        push_pc    = pq_pc_reg[pq_rd_reg];
        push_fault = imem_rsp_err_i;
        if (mis_push) begin
            push_instr = NOP;
            push_pc    = pc_i;
            push_fault = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
            fifo_cnt_reg <= '0;
            pq_wr_reg    <= '0;
            pq_rd_reg    <= '0;
            ff_wr_reg    <= '0;
            ff_rd_reg    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pq_pc_reg[i]    <= '0;
                ff_instr_reg[i] <= '0;
                ff_pc_reg[i]    <= '0;
                ff_fault_reg[i] <= 1'b0;
            end
        end else begin
            out_cnt_reg <= out_cnt_reg + CW'(accept) - CW'(imem_rsp_valid_i);

            // Every response pops the PC queue, discarded or not, so the
            // queue stays aligned with memory across flushes.
            if (accept) begin
                pq_pc_reg[pq_wr_reg] <= pc_i;
                pq_wr_reg            <= wrap_inc(pq_wr_reg);
            end
            if (imem_rsp_valid_i) begin
                pq_rd_reg <= wrap_inc(pq_rd_reg);
            end

            // On flush everything still outstanding after this cycle is stale;
            // a response consumed this cycle is no longer outstanding.
            if (flush_i) begin
                drop_cnt_reg <= out_cnt_reg - CW'(imem_rsp_valid_i);
            end else if (imem_rsp_valid_i && (drop_cnt_reg != '0)) begin
                drop_cnt_reg <= drop_cnt_reg - 1'b1;
            end

            if (flush_i) begin
                fifo_cnt_reg <= '0;
                ff_wr_reg    <= '0;
                ff_rd_reg    <= '0;
            end else begin
                if (ff_push) begin
                    ff_instr_reg[ff_wr_reg] <= push_instr;
                    ff_pc_reg[ff_wr_reg]    <= push_pc;
                    ff_fault_reg[ff_wr_reg] <= push_fault;
                    ff_wr_reg               <= wrap_inc(ff_wr_reg);
                end
                if (id_pop) begin
                    ff_rd_reg <= wrap_inc(ff_rd_reg);
                end
                fifo_cnt_reg <= fifo_cnt_reg + CW'(ff_push) - CW'(id_pop);
            end
        end
    end
endmodule
